// File: rtl/ej32_ls.sv
// ej32_ls: byte-serial load/store unit for a 32-bit core talking to an 8-bit memory.
//
// A request latches an address, direction, size and store data, then moves
// 1, 2 or 4 bytes over the byte bus, most significant byte first. Loads
// assemble the bytes into a word and optionally sign-extend byte and short
// results.
//
// Ports:
//   clk     - clock, all state changes on the rising edge
//   rst     - synchronous active-high reset
//   req     - transaction start, sampled only while idle
//   wr      - 1 = store, 0 = load
//   sz      - size: 00 byte, 01 short, 1x word
//   sx      - sign-extend the load result
//   addr    - base byte address
//   wdata   - store data, right-justified
//   mem_i   - memory read byte, valid one cycle after mem_a
//   mem_a   - memory byte address (0 when not transferring)
//   mem_we  - memory write strobe
//   mem_o   - memory write byte (0 when not writing)
//   busy    - high whenever a transaction is in progress
//   done    - one-cycle completion pulse
//   rdata   - last completed load result

module ej32_ls #(
    parameter int unsigned DSZ = 32,
    parameter int unsigned ASZ = 17
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req,
    input  logic           wr,
    input  logic [1:0]     sz,
    input  logic           sx,
    input  logic [ASZ-1:0] addr,
    input  logic [DSZ-1:0] wdata,
    input  logic [7:0]     mem_i,
    output logic [ASZ-1:0] mem_a,
    output logic           mem_we,
    output logic [7:0]     mem_o,
    output logic           busy,
    output logic           done,
    output logic [DSZ-1:0] rdata
);

    typedef enum logic [1:0] {
        StIdle,
        StXfer,
        StLast,
        StDone
    } state_e;

    state_e         state_q, state_d;
    logic [1:0]     i_q, i_d;          // byte index within the transfer
    logic [1:0]     last_q, last_d;    // index of the final byte (N-1)
    logic [ASZ-1:0] addr_q, addr_d;
    logic           wr_q, wr_d;
    logic           sx_q, sx_d;
    logic [DSZ-1:0] wdata_q, wdata_d;
    // The top byte of a fully shifted accumulator is always shifted out, so
    // only the low DSZ-8 bits are kept; the newest byte arrives on mem_i.
    logic [DSZ-9:0] acc_q, acc_d;
    logic [DSZ-1:0] rdata_q, rdata_d;

    logic [1:0]     sel;
    logic [7:0]     st_byte;
    logic [DSZ-1:0] ld_word;
    logic [DSZ-1:0] ld_result;

    // Big-endian byte select: byte i comes from position N-1-i.
    always_comb begin
        sel     = last_q - i_q;
        st_byte = 8'h00;
        unique case (sel)
            2'd0: st_byte = wdata_q[7:0];
            2'd1: st_byte = wdata_q[15:8];
            2'd2: st_byte = wdata_q[23:16];
            2'd3: st_byte = wdata_q[31:24];
        endcase
    end

    // Load result formed from the accumulator plus the final byte.
    always_comb begin
        ld_word = {acc_q, mem_i};
        case (last_q)
            2'd0:    ld_result = {{(DSZ-8){sx_q & ld_word[7]}}, ld_word[7:0]};
            2'd1:    ld_result = {{(DSZ-16){sx_q & ld_word[15]}}, ld_word[15:0]};
            default: ld_result = ld_word;
        endcase
    end

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        last_d  = last_q;
        addr_d  = addr_q;
        wr_d    = wr_q;
        sx_d    = sx_q;
        wdata_d = wdata_q;
        acc_d   = acc_q;
        rdata_d = rdata_q;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    addr_d  = addr;
                    wr_d    = wr;
                    sx_d    = sx;
                    wdata_d = wdata;
                    i_d     = 2'd0;
                    acc_d   = '0;
                    case (sz)
                        2'b00:   last_d = 2'd0;
                        2'b01:   last_d = 2'd1;
                        default: last_d = 2'd3;
                    endcase
                    state_d = StXfer;
                end
            end
            StXfer: begin
                // Read data lags the address by one cycle, so the first
                // XFER cycle has nothing to capture yet.
                if (!wr_q && (i_q != 2'd0)) begin
                    acc_d = {acc_q[DSZ-17:0], mem_i};
                end
                i_d = i_q + 2'd1;
                if (i_q == last_q) begin
                    state_d = wr_q ? StDone : StLast;
                end
            end
            StLast: begin
                rdata_d = ld_result;
                state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            i_q     <= 2'd0;
            last_q  <= 2'd0;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            sx_q    <= 1'b0;
            wdata_q <= '0;
            acc_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
            sx_q    <= sx_d;
            wdata_q <= wdata_d;
            acc_q   <= acc_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        busy   = (state_q != StIdle);
        done   = (state_q == StDone);
        mem_a  = '0;
        mem_we = 1'b0;
        mem_o  = 8'h00;
        if (state_q == StXfer) begin
            mem_a = addr_q + ASZ'(i_q);
            // The memory commits on the same edge that applies reset, so an
            // aborted store must not strobe in that cycle.
            if (wr_q && !rst) begin
                mem_we = 1'b1;
                mem_o  = st_byte;
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: tb/tb_ej32_ls.sv
// Scoreboard bench for ej32_ls: the stimulus process pushes the expected
// per-cycle bus trace of every transaction; a monitor pops and compares one
// entry per cycle against the DUT outputs.

module tb_ej32_ls;

    localparam int DSZ   = 32;
    localparam int ASZ   = 17;
    localparam int MSIZE = 1 << ASZ;

    logic           clk = 1'b0;
    logic           rst;
    logic           req;
    logic           wr;
    logic [1:0]     sz;
    logic           sx;
    logic [ASZ-1:0] addr;
    logic [DSZ-1:0] wdata;
    logic [7:0]     mem_i;
    logic [ASZ-1:0] mem_a;
    logic           mem_we;
    logic [7:0]     mem_o;
    logic           busy;
    logic           done;
    logic [DSZ-1:0] rdata;

    always #5 clk = ~clk;

    ej32_ls #(
        .DSZ(DSZ),
        .ASZ(ASZ)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .wr    (wr),
        .sz    (sz),
        .sx    (sx),
        .addr  (addr),
        .wdata (wdata),
        .mem_i (mem_i),
        .mem_a (mem_a),
        .mem_we(mem_we),
        .mem_o (mem_o),
        .busy  (busy),
        .done  (done),
        .rdata (rdata)
    );

    function automatic logic [7:0] init_byte(input int k);
        return 8'((k * 167) ^ (k >> 7));
    endfunction

    // Byte-wide memory with one-cycle read latency.
    logic [7:0] mem [MSIZE];
    logic       mem_ready = 1'b0;
    logic [7:0] mem_rd = 8'h00;
    assign mem_i = mem_rd;

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int k = 0; k < MSIZE; k++) mem[k] <= init_byte(k);
            mem_ready <= 1'b1;
        end else if (mem_we) begin
            mem[mem_a] <= mem_o;
        end
        mem_rd <= mem[mem_a];
    end

    typedef struct packed {
        logic           busy;
        logic           we;
        logic [ASZ-1:0] a;
        logic [7:0]     o;
        logic           done;
        logic [31:0]    rdata;
    } rec_t;

    rec_t        exp_q[$];
    logic [7:0]  ref_mem [MSIZE];
    logic [31:0] model_rdata = 32'h0;
    logic        mon_en = 1'b0;
    int          n_cmp = 0;
    int          n_fail = 0;

    function automatic rec_t mk(input logic b, input logic we, input logic [ASZ-1:0] a,
                                input logic [7:0] o, input logic d, input logic [31:0] rd);
        rec_t r;
        r.busy = b; r.we = we; r.a = a; r.o = o; r.done = d; r.rdata = rd;
        return r;
    endfunction

    // Monitor: one comparison per cycle, idle expectation when nothing queued.
    initial begin
        rec_t e;
        rec_t act;
        logic [31:0] last_rdata;
        last_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                act = mk(busy, mem_we, mem_a, mem_o, done, rdata);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    last_rdata = e.rdata;
                end else begin
                    e = mk(1'b0, 1'b0, '0, 8'h00, 1'b0, last_rdata);
                end
                n_cmp++;
                if (act !== e) begin
                    n_fail++;
                    $display("FAIL cycle_trace t=%0t got busy=%b we=%b a=%h o=%h done=%b rdata=%h exp busy=%b we=%b a=%h o=%h done=%b rdata=%h",
                             $time, act.busy, act.we, act.a, act.o, act.done, act.rdata,
                             e.busy, e.we, e.a, e.o, e.done, e.rdata);
                end
            end
        end
    end

    // mode 0: plain; mode 1: extra req in cycles 2-3; mode 2: reset in cycle 3 (word store).
    task automatic run_txn(input logic w, input logic [1:0] s, input logic x,
                           input logic [ASZ-1:0] a, input logic [31:0] d, input int mode);
        int             n;
        int             cnt;
        logic [ASZ-1:0] ad;
        logic [7:0]     b;
        logic [31:0]    v;
        n = (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
        exp_q.push_back(mk(1'b0, 1'b0, '0, 8'h00, 1'b0, model_rdata));
        if (w) begin
            for (int k = 0; k < n; k++) begin
                ad = ASZ'(int'(a) + k);
                b  = 8'(d >> (8 * (n - 1 - k)));
                if (mode == 2 && k == 2) begin
                    exp_q.push_back(mk(1'b1, 1'b0, ad, 8'h00, 1'b0, model_rdata));
                    model_rdata = 32'h0;
                    exp_q.push_back(mk(1'b0, 1'b0, '0, 8'h00, 1'b0, model_rdata));
                    break;
                end
                exp_q.push_back(mk(1'b1, 1'b1, ad, b, 1'b0, model_rdata));
                ref_mem[ad] = b;
            end
            if (mode != 2) exp_q.push_back(mk(1'b1, 1'b0, '0, 8'h00, 1'b1, model_rdata));
        end else begin
            v = 32'h0;
            for (int k = 0; k < n; k++) begin
                ad = ASZ'(int'(a) + k);
                exp_q.push_back(mk(1'b1, 1'b0, ad, 8'h00, 1'b0, model_rdata));
                v = (v << 8) | 32'(ref_mem[ad]);
            end
            exp_q.push_back(mk(1'b1, 1'b0, '0, 8'h00, 1'b0, model_rdata));
            if (n == 1 && x && v[7]) v = v | 32'hFFFF_FF00;
            if (n == 2 && x && v[15]) v = v | 32'hFFFF_0000;
            model_rdata = v;
            exp_q.push_back(mk(1'b1, 1'b0, '0, 8'h00, 1'b1, model_rdata));
        end
        // Cycle 0: present the request.
        wr = w; sz = s; sx = x; addr = a; wdata = d; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        if (mode == 1) begin
            @(posedge clk); #1;
            req = 1'b1; wr = ~w; sz = 2'($urandom); sx = ~x; addr = ~a; wdata = ~d;
            @(posedge clk); #1;
            @(posedge clk); #1;
            req = 1'b0;
        end else if (mode == 2) begin
            @(posedge clk); #1;
            @(posedge clk); #1;
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
        end
        cnt = 0;
        while (exp_q.size() != 0) begin
            @(posedge clk); #1;
            cnt++;
            if (cnt > 60) begin
                $display("FAIL scoreboard_drain remaining=%0d required=0", exp_q.size());
                $fatal(1, "scoreboard did not drain");
            end
        end
    endtask

    initial begin
        logic           w;
        logic [1:0]     s;
        logic [ASZ-1:0] a;
        int             mode;
        for (int k = 0; k < MSIZE; k++) ref_mem[k] = init_byte(k);
        rst = 1'b1; req = 1'b0; wr = 1'b0; sz = 2'b00; sx = 1'b0; addr = '0; wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        mon_en = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Directed cases.
        run_txn(1'b1, 2'b10, 1'b0, 17'h00100, 32'h1234_5678, 0);
        run_txn(1'b1, 2'b00, 1'b0, 17'h00200, 32'h0000_0080, 0);
        run_txn(1'b0, 2'b00, 1'b1, 17'h00200, 32'h0, 0);
        run_txn(1'b0, 2'b00, 1'b0, 17'h00200, 32'h0, 0);
        run_txn(1'b1, 2'b01, 1'b0, 17'h00300, 32'h0000_8001, 0);
        run_txn(1'b0, 2'b01, 1'b1, 17'h00300, 32'h0, 0);
        run_txn(1'b0, 2'b10, 1'b0, 17'h1FFFE, 32'h0, 0);
        run_txn(1'b1, 2'b10, 1'b0, 17'h00400, 32'hA1B2_C3D4, 1);
        run_txn(1'b0, 2'b11, 1'b0, 17'h00400, 32'h0, 0);
        run_txn(1'b1, 2'b10, 1'b0, 17'h00500, 32'hCAFE_F00D, 2);
        run_txn(1'b0, 2'b10, 1'b0, 17'h00500, 32'h0, 0);
        run_txn(1'b1, 2'b11, 1'b0, 17'h1FFFF, 32'h5566_7788, 0);
        run_txn(1'b0, 2'b10, 1'b1, 17'h1FFFF, 32'h0, 0);

        // Randomised traffic, biased toward the address wrap and a small window
        // so loads often see earlier stores.
        for (int t = 0; t < 300; t++) begin
            w = 1'($urandom);
            s = 2'($urandom);
            case ($urandom_range(0, 3))
                0:       a = ASZ'(17'h1FFFC + 17'($urandom_range(0, 3)));
                1:       a = ASZ'($urandom_range(0, 15));
                default: a = ASZ'($urandom);
            endcase
            mode = 0;
            if ($urandom_range(0, 9) == 0 && s[1]) mode = 1;
            if ($urandom_range(0, 19) == 0) begin
                w = 1'b1; s = 2'b10; mode = 2;
            end
            run_txn(w, s, 1'($urandom), a, $urandom, mode);
        end

        repeat (3) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
